// File: rtl/counter_pkg.sv
// Shared types and limits for the synchronous modulo-N counter family.
package counter_pkg;

    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 32;

    typedef enum logic {
        CNT_RUN  = 1'b0,
        CNT_DONE = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/cnt_term_detect.sv
// Combinational modulus decode: terminal value, terminal-step flag and clamp helpers.
module cnt_term_detect #(
    parameter int CNT_WIDTH = 8
) (
    input  logic [CNT_WIDTH-1:0] count,
    input  logic [CNT_WIDTH-1:0] max_count,
    input  logic                 up_dn,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] top,
    output logic                 term,
    output logic [CNT_WIDTH-1:0] load_clamped,
    output logic [CNT_WIDTH-1:0] count_clamped
);

    // N = 0 selects the full 2^CNT_WIDTH range, so TOP is all-ones.
    always_comb begin
        top = (max_count == '0) ? '1 : max_count - CNT_WIDTH'(1);
    end

    // >= rather than == so a modulus shrunk below the current count still terminates.
    assign term          = up_dn ? (count >= top) : (count == '0);
    assign load_clamped  = (load_val > top) ? top : load_val;
    assign count_clamped = (count > top) ? top : count;

endmodule

// File: rtl/sync_mod_counter.sv
// Fully synchronous modulo-N up/down counter with load, wrap/one-shot modes and registered tc.
module sync_mod_counter
    import counter_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 auto,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic [CNT_WIDTH-1:0] max_count,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] count_n,
    output logic                 tc,
    output logic                 counted_max
);

    if (CNT_WIDTH < CNT_WIDTH_MIN || CNT_WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
        $error("sync_mod_counter: CNT_WIDTH out of range");
    end

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 tc_q, tc_d;
    cnt_state_e           state_q, state_d;

    logic [CNT_WIDTH-1:0] top;
    logic                 term;
    logic [CNT_WIDTH-1:0] load_clamped;
    logic [CNT_WIDTH-1:0] count_clamped;

    cnt_term_detect #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_term (
        .count         (count_q),
        .max_count     (max_count),
        .up_dn         (up_dn),
        .load_val      (load_val),
        .top           (top),
        .term          (term),
        .load_clamped  (load_clamped),
        .count_clamped (count_clamped)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            state_q <= CNT_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        state_d = state_q;
        if (load) begin
            count_d = load_clamped;
            state_d = CNT_RUN;
        end else begin
            unique case (state_q)
                CNT_RUN: begin
                    if (en) begin
                        if (!term) begin
                            count_d = up_dn ? count_q + CNT_WIDTH'(1)
                                            : count_q - CNT_WIDTH'(1);
                        end else if (auto) begin
                            count_d = up_dn ? '0 : top;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_clamped;
                            tc_d    = 1'b1;
                            state_d = CNT_DONE;
                        end
                    end
                end
                CNT_DONE: begin
                    // Switching to auto releases the hold; stepping resumes next enabled cycle.
                    if (auto) state_d = CNT_RUN;
                end
                default: state_d = CNT_RUN;
            endcase
        end
    end

    assign count       = count_q;
    assign count_n     = ~count_q;
    assign tc          = tc_q;
    assign counted_max = (state_q == CNT_DONE);

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed scoreboard bench for sync_mod_counter at CNT_WIDTH = 4.
module tb_sync_mod_counter;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         cm;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr_n, en, up_dn, auto, load;
    logic [W-1:0] load_val, max_count;
    logic [W-1:0] count, count_n;
    logic         tc, counted_max;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    sync_mod_counter #(.CNT_WIDTH(W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .en          (en),
        .up_dn       (up_dn),
        .auto        (auto),
        .load        (load),
        .load_val    (load_val),
        .max_count   (max_count),
        .count       (count),
        .count_n     (count_n),
        .tc          (tc),
        .counted_max (counted_max)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the registers must hold after the edge.
    task automatic step(input logic c, input logic e, input logic u, input logic a,
                        input logic l, input logic [W-1:0] lv, input logic [W-1:0] mx,
                        input logic [W-1:0] ec, input logic etc, input logic ecm);
        exp_t x;
        @(negedge clk);
        clr_n = c; en = e; up_dn = u; auto = a; load = l; load_val = lv; max_count = mx;
        x.cnt = ec; x.tc = etc; x.cm = ecm;
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (count !== x.cnt) begin
                    errors++;
                    $display("FAIL count: got %0d want %0d", count, x.cnt);
                end
                checks++;
                if (count_n !== ~x.cnt) begin
                    errors++;
                    $display("FAIL count_n: got %0h want %0h", count_n, ~x.cnt);
                end
                checks++;
                if (tc !== x.tc) begin
                    errors++;
                    $display("FAIL tc: got %b want %b (count want %0d)", tc, x.tc, x.cnt);
                end
                checks++;
                if (counted_max !== x.cm) begin
                    errors++;
                    $display("FAIL counted_max: got %b want %b (count want %0d)", counted_max, x.cm, x.cnt);
                end
            end
        end
    end

    initial begin : stim
        clr_n = 1'b0; en = 1'b0; up_dn = 1'b1; auto = 1'b1; load = 1'b0;
        load_val = '0; max_count = '0;

        //    clr en up au ld lv  mx   cnt tc cm
        // Reset, then wrap-up mod 5
        step(0, 0, 1, 1, 0, 0,  5,   0, 0, 0);
        step(1, 1, 1, 1, 0, 0,  5,   1, 0, 0);
        step(1, 1, 1, 1, 0, 0,  5,   2, 0, 0);
        step(1, 1, 1, 1, 0, 0,  5,   3, 0, 0);
        step(1, 1, 1, 1, 0, 0,  5,   4, 0, 0);
        step(1, 1, 1, 1, 0, 0,  5,   0, 1, 0);
        step(1, 1, 1, 1, 0, 0,  5,   1, 0, 0);
        // Manual down from 3: terminal at 0, hold in DONE, load exits
        step(1, 0, 0, 0, 1, 3,  5,   3, 0, 0);
        step(1, 1, 0, 0, 0, 0,  5,   2, 0, 0);
        step(1, 1, 0, 0, 0, 0,  5,   1, 0, 0);
        step(1, 1, 0, 0, 0, 0,  5,   0, 0, 0);
        step(1, 1, 0, 0, 0, 0,  5,   0, 1, 1);
        step(1, 1, 0, 0, 0, 0,  5,   0, 0, 1);
        step(1, 1, 1, 0, 0, 0,  5,   0, 0, 1);
        step(1, 0, 0, 0, 1, 2,  5,   2, 0, 0);
        // Full-range wrap with N = 0
        step(1, 0, 1, 1, 1, 14, 0,  14, 0, 0);
        step(1, 1, 1, 1, 0, 0,  0,  15, 0, 0);
        step(1, 1, 1, 1, 0, 0,  0,   0, 1, 0);
        step(1, 1, 1, 1, 0, 0,  0,   1, 0, 0);
        // Modulus shrunk below count: auto wraps, manual clamps
        step(1, 0, 1, 1, 1, 7, 10,   7, 0, 0);
        step(1, 1, 1, 1, 0, 0,  4,   0, 1, 0);
        step(1, 0, 1, 0, 1, 7, 10,   7, 0, 0);
        step(1, 1, 1, 0, 0, 0,  4,   3, 1, 1);
        step(1, 1, 1, 0, 0, 0,  4,   3, 0, 1);
        step(1, 1, 1, 1, 0, 0,  4,   3, 0, 0);
        step(1, 1, 1, 1, 0, 0,  4,   0, 1, 0);
        // Load clamp, load beats en, en low holds
        step(1, 0, 1, 1, 1, 12, 6,   5, 0, 0);
        step(1, 1, 1, 1, 1, 2,  6,   2, 0, 0);
        step(1, 0, 1, 1, 0, 0,  6,   2, 0, 0);
        // Down wrap to TOP, and N = 1 back-to-back terminal steps
        step(1, 1, 0, 1, 1, 0,  5,   0, 0, 0);
        step(1, 1, 0, 1, 0, 0,  5,   4, 1, 0);
        step(1, 1, 1, 1, 0, 0,  1,   0, 1, 0);
        step(1, 1, 1, 1, 0, 0,  1,   0, 1, 0);
        step(1, 0, 1, 1, 0, 0,  1,   0, 0, 0);
        // Reset mid-count overrides load and en
        step(1, 0, 1, 1, 1, 8,  0,   8, 0, 0);
        step(1, 1, 1, 1, 0, 0,  0,   9, 0, 0);
        step(0, 1, 1, 1, 1, 7,  0,   0, 0, 0);
        step(0, 1, 1, 1, 0, 0,  0,   0, 0, 0);
        step(1, 1, 1, 1, 0, 0,  0,   1, 0, 0);

        step(1, 0, 1, 1, 0, 0,  0,   1, 0, 0);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || !stim_done) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, stim_done=%b", exp_q.size(), stim_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
